// File: rtl/uart_sdram_wr_packer_if.sv
// Byte-in / word-out bundle between the UART receive side and the SDRAM write FIFO.
// The packer takes the master modport; the receiver/controller side takes the slave modport.
interface uart_sdram_wr_packer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 19
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  flush;
    logic                  frame_restart;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  frame_done;
    logic                  overflow;

    modport master (
        input  byte_valid, byte_data, flush, frame_restart, wr_ready,
        output wr_valid, wr_data, wr_addr, frame_done, overflow
    );

    modport slave (
        output byte_valid, byte_data, flush, frame_restart, wr_ready,
        input  wr_valid, wr_data, wr_addr, frame_done, overflow
    );
endinterface

// File: rtl/uart_sdram_wr_packer.sv
// Packs UART bytes into DATA_WIDTH words with a wrapping frame address.
// Two stages: an assembly register (p0) feeding a valid/ready output register (p1).
module uart_sdram_wr_packer #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 19,
    parameter int FRAME_WORDS    = 307200,
    parameter int BYTE_ORDER     = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   Sys_clk,
    input  logic                   Rst,
    uart_sdram_wr_packer_if.master bus
);
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_M1  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0]      LAST_SLOT = CNT_W'(BPW - 1);
    localparam logic [IDLE_W-1:0]     IDLE_MAX  = IDLE_W'(TO_M1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    logic [CNT_W-1:0]      cnt_p0;
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] asm_p0;
    logic [IDLE_W-1:0]     idle_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  frame_done_q;
    logic                  overflow_q;

    logic                  hs;
    logic                  xfer;
    logic                  addr_at_end;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  full_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] asm_nxt;
    logic                  drop;
    logic                  idle_hit;
    logic [IDLE_W-1:0]     idle_nxt;

    function automatic logic [DATA_WIDTH-1:0] put_byte(
        input logic [DATA_WIDTH-1:0] w,
        input logic [CNT_W-1:0]      slot,
        input logic [7:0]            b
    );
        logic [DATA_WIDTH-1:0] r;
        int                    pos;
        r   = w;
        pos = (BYTE_ORDER == 0) ? (BPW - 1 - int'(slot)) : int'(slot);
        r[pos*8 +: 8] = b;
        return r;
    endfunction

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (v == IDLE_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        hs          = vld_p1 & bus.wr_ready;
        xfer        = vld_p0 & (~vld_p1 | bus.wr_ready);
        addr_at_end = (addr_cnt == LAST_ADDR);
        addr_nxt    = addr_cnt;
        if (hs) begin
            addr_nxt = addr_at_end ? '0 : addr_cnt + 1'b1;
        end

        full_nxt = vld_p0 & ~xfer;
        cnt_nxt  = cnt_p0;
        asm_nxt  = asm_p0;
        drop     = 1'b0;
        if (bus.byte_valid) begin
            if (full_nxt) begin
                drop = 1'b1;
            end else begin
                // Slot 0 starts a fresh word, so stale bytes never leak into a padded flush.
                asm_nxt = put_byte((cnt_p0 == '0) ? '0 : asm_p0, cnt_p0, bus.byte_data);
                if (cnt_p0 == LAST_SLOT) begin
                    full_nxt = 1'b1;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
        end

        idle_hit = (TIMEOUT_CYCLES != 0) && !bus.byte_valid && (cnt_p0 != '0)
                   && !vld_p0 && (idle_p0 == IDLE_MAX);
        if ((bus.flush || idle_hit) && (cnt_nxt != '0) && !full_nxt) begin
            full_nxt = 1'b1;
            cnt_nxt  = '0;
        end

        idle_nxt = (bus.byte_valid || (cnt_p0 == '0) || vld_p0 || idle_hit)
                   ? '0 : sat_inc(idle_p0);
    end

    // p0: assembly register contents
    always_ff @(posedge Sys_clk) begin
        asm_p0 <= asm_nxt;
    end

    // p0/p1 control and output register
    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            cnt_p0       <= '0;
            vld_p0       <= 1'b0;
            idle_p0      <= '0;
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            addr_p1      <= '0;
            addr_cnt     <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (bus.frame_restart) begin
            cnt_p0       <= '0;
            vld_p0       <= 1'b0;
            idle_p0      <= '0;
            vld_p1       <= 1'b0;
            addr_cnt     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_p0       <= cnt_nxt;
            vld_p0       <= full_nxt;
            idle_p0      <= idle_nxt;
            addr_cnt     <= addr_nxt;
            frame_done_q <= hs & addr_at_end;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            // A word loaded alongside a handshake takes the already-advanced address.
            if (xfer) begin
                vld_p1  <= 1'b1;
                data_p1 <= asm_p0;
                addr_p1 <= addr_nxt;
            end else if (hs) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.wr_valid   = vld_p1;
    assign bus.wr_data    = data_p1;
    assign bus.wr_addr    = addr_p1;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_sdram_wr_packer.sv
// Bench for uart_sdram_wr_packer: a 16-bit MSB-first instance with a 4-word frame and
// 16-cycle timeout, and a 32-bit LSB-first instance, each shadowed by a byte-list model.
module tb_uart_sdram_wr_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_sdram_wr_packer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(19)) ifa ();
    uart_sdram_wr_packer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(19)) ifb ();

    uart_sdram_wr_packer #(
        .DATA_WIDTH(16), .ADDR_WIDTH(19), .FRAME_WORDS(4), .BYTE_ORDER(0), .TIMEOUT_CYCLES(16)
    ) dut_a (.Sys_clk(clk), .Rst(rst), .bus(ifa));

    uart_sdram_wr_packer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(19), .FRAME_WORDS(307200), .BYTE_ORDER(1), .TIMEOUT_CYCLES(0)
    ) dut_b (.Sys_clk(clk), .Rst(rst), .bus(ifb));

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    int fd_cnt_a = 0;

    int P_BPW[2] = '{2, 4};
    int P_BO[2]  = '{0, 1};
    int P_FW[2]  = '{4, 307200};
    int P_TO[2]  = '{16, 0};

    // Model state: bytes collected for the word being assembled, plus the output word.
    int          m_n[2];
    bit          m_full[2];
    logic [7:0]  m_b[2][8];
    bit          m_valid[2];
    logic [63:0] m_data[2];
    int          m_addr[2];
    int          m_ac[2];
    int          m_idle[2];
    bit          m_fd[2];
    bit          m_ov[2];

    logic [95:0] dq_a[$];
    logic [95:0] mq_a[$];
    logic [95:0] dq_b[$];
    logic [95:0] mq_b[$];
    logic [95:0] exp_q[$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] W(input logic [31:0] a, input logic [63:0] d);
        return {a, d};
    endfunction

    function automatic logic [63:0] pack(input int i);
        logic [63:0] w;
        w = '0;
        for (int s = 0; s < m_n[i]; s++) begin
            int pos;
            pos = (P_BO[i] == 0) ? (P_BPW[i] - 1 - s) : s;
            w[pos*8 +: 8] = m_b[i][s];
        end
        return w;
    endfunction

    function automatic void step(input int i, input logic r, input logic bv, input logic [7:0] bd,
                                 input logic fl, input logic fr, input logic rdy);
        bit hs, xf, busy, hit;
        int idle_n;
        if (r) begin
            m_n[i] = 0; m_full[i] = 0; m_valid[i] = 0; m_data[i] = '0; m_addr[i] = 0;
            m_ac[i] = 0; m_idle[i] = 0; m_fd[i] = 0; m_ov[i] = 0;
            return;
        end
        if (fr) begin
            m_n[i] = 0; m_full[i] = 0; m_valid[i] = 0; m_ac[i] = 0; m_idle[i] = 0; m_fd[i] = 0;
            return;
        end
        busy   = (m_n[i] > 0) && !m_full[i];
        hit    = (P_TO[i] > 0) && !bv && busy && (m_idle[i] + 1 == P_TO[i]);
        idle_n = (!bv && busy && !hit) ? m_idle[i] + 1 : 0;
        hs     = m_valid[i] && rdy;
        xf     = m_full[i] && (!m_valid[i] || rdy);
        m_fd[i] = hs && (m_ac[i] == P_FW[i] - 1);
        if (hs) begin
            if (i == 0) mq_a.push_back(W(32'(m_addr[i]), m_data[i]));
            else        mq_b.push_back(W(32'(m_addr[i]), m_data[i]));
            m_ac[i] = (m_ac[i] == P_FW[i] - 1) ? 0 : m_ac[i] + 1;
        end
        if (xf) begin
            m_data[i] = pack(i); m_addr[i] = m_ac[i]; m_valid[i] = 1; m_full[i] = 0; m_n[i] = 0;
        end else if (hs) begin
            m_valid[i] = 0;
        end
        if (bv) begin
            if (m_full[i]) m_ov[i] = 1;
            else begin
                m_b[i][m_n[i]] = bd;
                m_n[i]++;
                if (m_n[i] == P_BPW[i]) m_full[i] = 1;
            end
        end
        if ((fl || hit) && (m_n[i] > 0) && !m_full[i]) m_full[i] = 1;
        m_idle[i] = idle_n;
    endfunction

    always @(posedge clk) begin
        step(0, rst, ifa.byte_valid, ifa.byte_data, ifa.flush, ifa.frame_restart, ifa.wr_ready);
        step(1, rst, ifb.byte_valid, ifb.byte_data, ifb.flush, ifb.frame_restart, ifb.wr_ready);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_wr_valid", 96'(ifa.wr_valid), 96'(m_valid[0]));
            chk("a_frame_done", 96'(ifa.frame_done), 96'(m_fd[0]));
            chk("a_overflow", 96'(ifa.overflow), 96'(m_ov[0]));
            if (m_valid[0]) begin
                chk("a_wr_data", 96'(ifa.wr_data), 96'(m_data[0]));
                chk("a_wr_addr", 96'(ifa.wr_addr), 96'(m_addr[0]));
            end
            chk("b_wr_valid", 96'(ifb.wr_valid), 96'(m_valid[1]));
            chk("b_frame_done", 96'(ifb.frame_done), 96'(m_fd[1]));
            chk("b_overflow", 96'(ifb.overflow), 96'(m_ov[1]));
            if (m_valid[1]) begin
                chk("b_wr_data", 96'(ifb.wr_data), 96'(m_data[1]));
                chk("b_wr_addr", 96'(ifb.wr_addr), 96'(m_addr[1]));
            end
            if (ifa.wr_valid && ifa.wr_ready && !rst && !ifa.frame_restart)
                dq_a.push_back(W(32'(ifa.wr_addr), 64'(ifa.wr_data)));
            if (ifb.wr_valid && ifb.wr_ready && !rst && !ifb.frame_restart)
                dq_b.push_back(W(32'(ifb.wr_addr), 64'(ifb.wr_data)));
            if (ifa.frame_done) fd_cnt_a++;
        end
    end

    task automatic cmp_list(input int i, input string nm);
        logic [95:0] d[$];
        logic [95:0] m[$];
        if (i == 0) begin d = dq_a; m = mq_a; dq_a.delete(); mq_a.delete(); end
        else        begin d = dq_b; m = mq_b; dq_b.delete(); mq_b.delete(); end
        chk({nm, "_dut_count"}, 96'(d.size()), 96'(exp_q.size()));
        chk({nm, "_model_count"}, 96'(m.size()), 96'(exp_q.size()));
        foreach (exp_q[k]) begin
            chk($sformatf("%s_dut_word%0d", nm, k), (k < d.size()) ? d[k] : {96{1'bx}}, exp_q[k]);
            chk($sformatf("%s_model_word%0d", nm, k), (k < m.size()) ? m[k] : {96{1'bx}}, exp_q[k]);
        end
        exp_q.delete();
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [7:0] b);
        ifa.byte_valid = 1'b1; ifa.byte_data = b; cyc(); ifa.byte_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        ifb.byte_valid = 1'b1; ifb.byte_data = b; cyc(); ifb.byte_valid = 1'b0;
    endtask

    task automatic restart_a();
        ifa.frame_restart = 1'b1; cyc(); ifa.frame_restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.byte_valid = 0; ifa.byte_data = 0; ifa.flush = 0; ifa.frame_restart = 0; ifa.wr_ready = 1;
        ifb.byte_valid = 0; ifb.byte_data = 0; ifb.flush = 0; ifb.frame_restart = 0; ifb.wr_ready = 1;
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("rst_a_valid", 96'(ifa.wr_valid), 96'(0));
        chk("rst_a_data", 96'(ifa.wr_data), 96'(0));
        chk("rst_a_addr", 96'(ifa.wr_addr), 96'(0));
        chk("rst_a_frame_done", 96'(ifa.frame_done), 96'(0));
        chk("rst_a_overflow", 96'(ifa.overflow), 96'(0));
        chk("rst_b_valid", 96'(ifb.wr_valid), 96'(0));
        rst = 1'b0;
        cyc();

        // Two 16-bit words, MSB first; valid rises two edges after each second byte.
        send_a(8'h12); send_a(8'h34);
        chk("t1_valid_wait", 96'(ifa.wr_valid), 96'(0));
        send_a(8'h56);
        chk("t1_valid_up", 96'(ifa.wr_valid), 96'(1));
        chk("t1_data_w0", 96'(ifa.wr_data), 96'h1234);
        send_a(8'h78);
        cyc(3);
        exp_q = '{W(32'd0, 64'h1234), W(32'd1, 64'h5678)};
        cmp_list(0, "t1");

        // Byte and flush in the same cycle, then a flush with nothing buffered.
        ifa.flush = 1'b1; send_a(8'hC3); ifa.flush = 1'b0;
        cyc(3);
        exp_q = '{W(32'd2, 64'hC300)};
        cmp_list(0, "byte_flush");
        ifa.flush = 1'b1; cyc(); ifa.flush = 1'b0;
        cyc(3);
        cmp_list(0, "empty_flush_a");

        // Idle timeout pads a lone byte; a byte at idle cycle 10 restarts the count.
        fd_cnt_a = 0;
        send_a(8'h5A);
        cyc(15);
        chk("t5_idle15", 96'(ifa.wr_valid), 96'(0));
        cyc();
        chk("t5_idle16", 96'(ifa.wr_valid), 96'(0));
        cyc();
        chk("t5_emit_valid", 96'(ifa.wr_valid), 96'(1));
        chk("t5_emit_data", 96'(ifa.wr_data), 96'h5A00);
        cyc(2);
        send_a(8'h77); cyc(9); send_a(8'h88);
        cyc(3);
        exp_q = '{W(32'd3, 64'h5A00), W(32'd0, 64'h7788)};
        cmp_list(0, "t5");
        chk("t5_frame_done_pulses", 96'(fd_cnt_a), 96'(1));

        // Ten back-to-back words over a 4-word frame.
        restart_a();
        fd_cnt_a = 0;
        for (int k = 0; k < 20; k++) send_a(8'(k + 16));
        cyc(3);
        for (int k = 0; k < 10; k++)
            exp_q.push_back(W(32'(k % 4), 64'(((2*k + 16) << 8) | (2*k + 17))));
        cmp_list(0, "t6_wrap");
        chk("t6_frame_done_pulses", 96'(fd_cnt_a), 96'(2));

        // Restart mid-word: partial byte and the same-cycle byte are discarded silently.
        send_a(8'hE1);
        ifa.frame_restart = 1'b1; send_a(8'hE2); ifa.frame_restart = 1'b0;
        send_a(8'hF0); send_a(8'hF1);
        cyc(3);
        exp_q = '{W(32'd0, 64'hF0F1)};
        cmp_list(0, "t6_restart");
        chk("t6_no_overflow", 96'(ifa.overflow), 96'(0));

        // Back-pressure: one word held in OUT, one in ASM, the rest dropped.
        restart_a();
        ifa.wr_ready = 1'b0;
        for (int k = 1; k <= 6; k++) send_a(8'(k));
        chk("t3_overflow", 96'(ifa.overflow), 96'(1));
        chk("t3_hold_valid", 96'(ifa.wr_valid), 96'(1));
        chk("t3_hold_data", 96'(ifa.wr_data), 96'h0102);
        chk("t3_hold_addr", 96'(ifa.wr_addr), 96'(0));
        ifa.wr_ready = 1'b1;
        cyc(3);
        exp_q = '{W(32'd0, 64'h0102), W(32'd1, 64'h0304)};
        cmp_list(0, "t3");
        chk("t3_overflow_sticky", 96'(ifa.overflow), 96'(1));

        // Reset in the middle of a stalled stream.
        ifa.wr_ready = 1'b0;
        send_a(8'hA1); send_a(8'hA2); send_a(8'hA3);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mid_rst_valid", 96'(ifa.wr_valid), 96'(0));
        chk("mid_rst_data", 96'(ifa.wr_data), 96'(0));
        chk("mid_rst_addr", 96'(ifa.wr_addr), 96'(0));
        chk("mid_rst_frame_done", 96'(ifa.frame_done), 96'(0));
        chk("mid_rst_overflow", 96'(ifa.overflow), 96'(0));
        ifa.wr_ready = 1'b1;
        send_a(8'hB1); send_a(8'hB2);
        cyc(3);
        exp_q = '{W(32'd0, 64'hB1B2)};
        cmp_list(0, "after_rst");

        // 32-bit LSB-first packing and a zero-padded flush.
        send_b(8'h11); send_b(8'h22); send_b(8'h33); send_b(8'h44);
        chk("t2_valid_wait", 96'(ifb.wr_valid), 96'(0));
        cyc();
        chk("t2_valid_up", 96'(ifb.wr_valid), 96'(1));
        chk("t2_data", 96'(ifb.wr_data), 96'h44332211);
        cyc(3);
        exp_q = '{W(32'd0, 64'h44332211)};
        cmp_list(1, "t2");
        send_b(8'hAA); send_b(8'hBB);
        ifb.flush = 1'b1; cyc(); ifb.flush = 1'b0;
        cyc(3);
        exp_q = '{W(32'd1, 64'h0000BBAA)};
        cmp_list(1, "t4_flush");
        ifb.flush = 1'b1; cyc(); ifb.flush = 1'b0;
        cyc(3);
        cmp_list(1, "t4_empty_flush");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
